wbu_arb: RTL
============

WBU_ARB -- requirements
Module: wbu_arb

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high, named i_clk and i_rst; all state changes on rising i_clk.
REQ-002 NUM_REQ, default 3, number of writeback requesters: 0=ALU/PC, 1=LSU load return, 2=MDU.
REQ-003 i_clk  in  1  core clock.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_req_valid  in  NUM_REQ  per-requester write request.
REQ-006 o_req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 i_req_id  in  NUM_REQ*`GPRS_WIDTH  packed destination GPR ids, requester k at slice k.
REQ-008 i_req_data  in  NUM_REQ*`DATA_WIDTH  packed write data, requester k at slice k.
REQ-009 i_wb_ready  in  1  downstream commit ready, i.e. the system writeback handshake.
REQ-010 o_wb_valid  out  1  output stage holds a pending write.
REQ-011 o_wbu_gpr_wr_en / o_wbu_gpr_wr_id / o_wbu_gpr_wr_data  out  1/`GPRS_WIDTH/`DATA_WIDTH  register-file write port.
REQ-012 i_iss_valid / i_iss_id  in  1/`GPRS_WIDTH  instruction issue with a pending GPR destination.
REQ-013 o_gpr_busy  out  2**`GPRS_WIDTH  per-GPR pending-write flags.

Function
REQ-014 Output stage: one register holding out_valid, out_id and out_data.
REQ-015 can_accept = !out_valid || i_wb_ready.
REQ-016 Commit condition: commit = out_valid && i_wb_ready.
REQ-017 Grant: round-robin over requesters with valid set, searching from rr_ptr upward modulo NUM_REQ; at most one grant per cycle.
REQ-018 Ready: o_req_ready[k] = grant[k] && can_accept, combinational; o_req_ready is zero when no request is valid.
REQ-019 Transfer: a transfer occurs when i_req_valid[k] && o_req_ready[k]; the granted id and data load the output register the same edge; latency is 1 cycle from transfer to o_wb_valid.
REQ-020 Pointer update: after a transfer from k, rr_ptr = (k+1) mod NUM_REQ; with no transfer, rr_ptr holds.
REQ-021 No pending write: if there is no commit and no transfer, out_valid is held; if there is a commit with no transfer, out_valid clears next cycle.
REQ-022 Simultaneous commit and transfer: the new entry replaces the committed one with no bubble, giving full throughput of 1 write/cycle.
REQ-023 Write enable: o_wbu_gpr_wr_en = commit && (out_id != 0); a write to x0 is consumed without asserting the enable.
REQ-024 Idle port values: o_wbu_gpr_wr_id and o_wbu_gpr_wr_data equal out_id/out_data when out_valid, else zero.
REQ-025 Requester obligation: a requester holds valid/id/data stable until accepted; the arbiter does not check this.

Reset
REQ-026 While i_rst is high: rr_ptr=0, out_valid=0, out_id=0, out_data=0, o_gpr_busy=0, and every o_req_ready is 0.
REQ-027 Reset mid-operation discards any pending output entry without asserting a write enable; grants resume on the first cycle after reset deasserts.

Configuration
REQ-028 Macro WBU_ARB_SCOREBOARD_EN defined: a busy bit is set on i_iss_valid for i_iss_id != 0 and cleared on commit of out_id.
REQ-029 Same-cycle set and clear of one id (WBU_ARB_SCOREBOARD_EN defined): set wins, leaving the bit busy.
REQ-030 Busy bit 0: always 0.
REQ-031 Macro WBU_ARB_SCOREBOARD_EN undefined: o_gpr_busy is tied to zero, i_iss_* are ignored, and no scoreboard flops exist; ports are present in both builds.

Structure
REQ-032 Shared core package: requester index constants (REQ_ALU=0, REQ_LSU=1, REQ_MDU=2) and a wb_req_t struct {id, data}.
REQ-033 Existing cfg.sv: width macros `GPRS_WIDTH, `DATA_WIDTH and `DATA_ZERO are taken from here.
REQ-034 Sub-module rr_arb (parameterised N, req in, ptr in, one-hot grant out): the grant logic lives here; wbu_arb holds the pointer, output stage and scoreboard.

Verification
REQ-035 Single write: only req1 valid (id=5, data=0xDEADBEEF), i_wb_ready=1 -> ready1 same cycle; next cycle wr_en=1, id=5, data=0xDEADBEEF.
REQ-036 Contention fairness: all three valid continuously after reset, ready=1 -> grants in order 0,1,2,0,1,2, one commit per cycle with no bubbles.
REQ-037 Backpressure: i_wb_ready=0 for 3 cycles with out_valid set -> all o_req_ready=0, output held stable; ready=1 -> commit, and the next grant loads the same edge.
REQ-038 x0 write: req0 id=0, data=0x1234 -> o_wb_valid=1, wr_en=0; the entry is consumed next cycle.
REQ-039 Scoreboard (macro defined): issue id=7 -> busy[7]=1; commit of id=7 in the same cycle as a new issue of id=7 -> busy[7] stays 1; a lone commit clears it.
REQ-040 Reset with pending write: assert i_rst with out_valid=1 -> no wr_en pulse, all outputs zero the next cycle, and rr_ptr=0 so req0 wins first after release.

Source files
------------

// File: rtl/wbu_arb_pkg.sv
// Shared writeback definitions: requester indices and the request payload.
// Width macros normally come from cfg.sv; the guarded defaults match it.
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

package wbu_arb_pkg;
   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;
   localparam int REQ_MDU = 2;

   typedef struct packed {
      logic [`GPRS_WIDTH-1:0] id;
      logic [`DATA_WIDTH-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/cfg.sv
// Core-wide width configuration shared by the writeback path.
// Guarded so files that fall back to these defaults stay consistent.
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

// File: rtl/rr_arb.sv
// Round-robin grant: first valid requester at or above ptr, wrapping modulo N.
// Purely combinational; the caller owns the pointer.
module rr_arb #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);
   logic found;
   int   idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wbu_arb.sv
// Writeback arbiter: round-robin over requesters into a single output stage.
// Optional GPR busy scoreboard enabled by WBU_ARB_SCOREBOARD_EN.
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_ZERO
`define DATA_ZERO 32'h0000_0000
`endif

module wbu_arb
   import wbu_arb_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic [NUM_REQ-1:0]                 i_req_valid,
   output logic [NUM_REQ-1:0]                 o_req_ready,
   input  logic [NUM_REQ*`GPRS_WIDTH-1:0]     i_req_id,
   input  logic [NUM_REQ*`DATA_WIDTH-1:0]     i_req_data,
   input  logic                               i_wb_ready,
   output logic                               o_wb_valid,
   output logic                               o_wbu_gpr_wr_en,
   output logic [`GPRS_WIDTH-1:0]             o_wbu_gpr_wr_id,
   output logic [`DATA_WIDTH-1:0]             o_wbu_gpr_wr_data,
   input  logic                               i_iss_valid,
   input  logic [`GPRS_WIDTH-1:0]             i_iss_id,
   output logic [(1<<`GPRS_WIDTH)-1:0]        o_gpr_busy
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic               out_valid_q, out_valid_d;
   wb_req_t            out_q, out_d;
   wb_req_t            sel;
   logic [NUM_REQ-1:0] grant;
   logic               can_accept, commit, xfer;

   rr_arb #(.N(NUM_REQ), .PW(PW)) u_rr_arb (
      .req   (i_req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   assign can_accept = !out_valid_q || i_wb_ready;
   assign commit     = out_valid_q && i_wb_ready && !i_rst;
   // Outputs are forced quiet during reset so a pending entry never commits.
   assign o_req_ready = (can_accept && !i_rst) ? grant : '0;
   assign xfer        = |(i_req_valid & o_req_ready);

   always_comb begin
      sel      = '0;
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel.id   = i_req_id[k*`GPRS_WIDTH +: `GPRS_WIDTH];
            sel.data = i_req_data[k*`DATA_WIDTH +: `DATA_WIDTH];
            if (xfer) rr_ptr_d = PW'((k + 1) % NUM_REQ);
         end
      end
   end

   // A same-cycle commit and transfer simply overwrites the stage: no bubble.
   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_d       = sel;
      end else if (commit) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_q.id    <= '0;
         out_q.data  <= `DATA_ZERO;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign o_wb_valid        = out_valid_q && !i_rst;
   assign o_wbu_gpr_wr_en   = commit && (out_q.id != '0);
   assign o_wbu_gpr_wr_id   = o_wb_valid ? out_q.id : '0;
   assign o_wbu_gpr_wr_data = o_wb_valid ? out_q.data : `DATA_ZERO;

`ifdef WBU_ARB_SCOREBOARD_EN
   logic [(1<<`GPRS_WIDTH)-1:0] busy_q, busy_d;

   // Clear first, then set, so a same-cycle reissue keeps the bit busy.
   always_comb begin
      busy_d = busy_q;
      if (commit) busy_d[out_q.id] = 1'b0;
      if (i_iss_valid && (i_iss_id != '0)) busy_d[i_iss_id] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign o_gpr_busy = i_rst ? '0 : busy_q;
`else
   logic unused_iss;
   assign unused_iss = ^{i_iss_valid, i_iss_id};
   assign o_gpr_busy = '0;
`endif
endmodule
